// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and EPC, selects the next-PC source
// each cycle (sequential, redirect, exception vector, RTI return or hold),
// inserts a one-cycle fetch-flush bubble on control transfers and stops on HALT.
// Optional build macro: NESTED_EXC_GUARD_EN. When it is defined, an exception
// raised inside a handler halts the machine with a sticky err instead of
// overwriting epc.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] target,
  input  logic        siic,
  input  logic        rti,
  input  logic        halt,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [15:0] epc,
  output logic        flush,
  output logic        in_exc,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HALT
  } state_t;

  state_t      state, state_next;
  logic [15:0] pc_next, epc_next;
  logic        in_exc_next, err_next;

  // Sequential successor; the 16-bit result wraps FFFE -> 0000 on its own.
  assign pc_plus2 = pc + 16'd2;
  assign flush    = (state == ST_FLUSH);
  assign halted   = (state == ST_HALT);

  // State, PC and exception registers.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      pc     <= RESET_PC;
      epc    <= 16'h0000;
      in_exc <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      epc    <= epc_next;
      in_exc <= in_exc_next;
      err    <= err_next;
    end
  end

  // Next-state and next-PC selection with fixed event priority in RUN.
  always_comb begin
    // NOTE: every target gets a hold default first, so no path infers a latch.
    state_next  = state;
    pc_next     = pc;
    epc_next    = epc;
    in_exc_next = in_exc;
    err_next    = err;

    unique case (state)
      ST_RUN: begin
        if (halt) begin
          state_next = ST_HALT;
        end else if (siic) begin
`ifdef NESTED_EXC_GUARD_EN
          if (in_exc) begin
            // Nested exception: keep the original return address and stop.
            err_next   = 1'b1;
            state_next = ST_HALT;
          end else begin
            epc_next    = pc_plus2;
            pc_next     = EXC_VECTOR;
            in_exc_next = 1'b1;
            state_next  = ST_FLUSH;
          end
`else
          epc_next    = pc_plus2;
          pc_next     = EXC_VECTOR;
          in_exc_next = 1'b1;
          state_next  = ST_FLUSH;
`endif
        end else if (rti) begin
          pc_next     = epc;
          in_exc_next = 1'b0;
          state_next  = ST_FLUSH;
        end else if (redirect) begin
          pc_next    = target;
          state_next = ST_FLUSH;
        end else if (!stall) begin
          pc_next = pc_plus2;
        end
      end

      // One bubble cycle: pc holds on the new target; only halt is honoured
      // because the other requests come from the squashed instruction.
      ST_FLUSH: begin
        state_next = halt ? ST_HALT : ST_RUN;
      end

      // Terminal until reset: everything frozen.
      ST_HALT: begin
        state_next = ST_HALT;
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a behavioural model pushes the
// expected post-edge outputs into a queue as each cycle's stimulus is driven;
// they are popped and compared just after the rising edge. Directed checks
// pin down the concrete addresses of the key scenarios.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall, redirect, siic, rti, halt;
  logic [15:0] target;
  logic [15:0] pc, pc_plus2, epc;
  logic        flush, in_exc, halted, err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] epc;
    logic [15:0] pc_plus2;
    logic        flush;
    logic        in_exc;
    logic        halted;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Model state: 0 = run, 1 = flush, 2 = halt.
  logic [15:0] m_pc, m_epc;
  logic        m_in_exc, m_err;
  int          m_st;

  pc_sequencer #(
    .RESET_PC  (16'h0000),
    .EXC_VECTOR(16'h0002)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stall),
    .redirect(redirect),
    .target  (target),
    .siic    (siic),
    .rti     (rti),
    .halt    (halt),
    .pc      (pc),
    .pc_plus2(pc_plus2),
    .epc     (epc),
    .flush   (flush),
    .in_exc  (in_exc),
    .halted  (halted),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.pc       = m_pc;
    e.epc      = m_epc;
    e.pc_plus2 = m_pc + 16'd2;
    e.flush    = (m_st == 1);
    e.in_exc   = m_in_exc;
    e.halted   = (m_st == 2);
    e.err      = m_err;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_epc = 16'h0000; m_in_exc = 1'b0; m_err = 1'b0; m_st = 0;
  endtask

  task automatic compare_outputs(input exp_t e, input string pfx);
    check({pfx, "_pc"},       pc,       e.pc);
    check({pfx, "_epc"},      epc,      e.epc);
    check({pfx, "_pc_plus2"}, pc_plus2, e.pc_plus2);
    check({pfx, "_flush"},    16'(flush),  16'(e.flush));
    check({pfx, "_in_exc"},   16'(in_exc), 16'(e.in_exc));
    check({pfx, "_halted"},   16'(halted), 16'(e.halted));
    check({pfx, "_err"},      16'(err),    16'(e.err));
  endtask

  // Drive one cycle of stimulus (called at a falling edge), advance the model,
  // push its expectation, then compare just after the rising edge.
  task automatic step(input logic s, input logic r, input logic [15:0] t,
                      input logic x, input logic ri, input logic h);
    logic [15:0] p2;
    exp_t        e;
    stall = s; redirect = r; target = t; siic = x; rti = ri; halt = h;
    p2 = m_pc + 16'd2;
    if (m_st == 0) begin
      if (h) m_st = 2;
      else if (x) begin
`ifdef NESTED_EXC_GUARD_EN
        if (m_in_exc) begin m_err = 1'b1; m_st = 2; end
        else begin m_epc = p2; m_pc = 16'h0002; m_in_exc = 1'b1; m_st = 1; end
`else
        m_epc = p2; m_pc = 16'h0002; m_in_exc = 1'b1; m_st = 1;
`endif
      end
      else if (ri) begin m_pc = m_epc; m_in_exc = 1'b0; m_st = 1; end
      else if (r)  begin m_pc = t; m_st = 1; end
      else if (!s) m_pc = p2;
    end else if (m_st == 1) begin
      m_st = h ? 2 : 0;
    end
    exp_q.push_back(model_view());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare_outputs(e, "cyc");
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Redirect to addr and burn the flush cycle, leaving RUN at pc=addr.
  task automatic goto_pc(input logic [15:0] addr);
    step(1'b0, 1'b1, addr, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  // Asynchronous reset pulse, checked immediately (no clock edge needed).
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs(model_view(), "rst");
    check("rst_pc_const", pc, 16'h0000);
    check("rst_halted_const", 16'(halted), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; redirect = 0; target = 16'h0; siic = 0; rti = 0; halt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_outputs(model_view(), "init");
    rst_n = 1'b1;

    // Free-running from reset: 0000, 0002, 0004, 0006.
    check("seq0", pc, 16'h0000);
    idle(); check("seq1", pc, 16'h0002);
    idle(); check("seq2", pc, 16'h0004);
    idle(); check("seq3", pc, 16'h0006);
    check("seq3_flush", 16'(flush), 16'h0);

    // Redirect at 0010 -> 0100 with one bubble, then 0102.
    goto_pc(16'h0010);
    step(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    check("br_pc", pc, 16'h0100);
    check("br_flush", 16'(flush), 16'h1);
    idle(); check("br_hold_pc", pc, 16'h0100); check("br_hold_flush", 16'(flush), 16'h0);
    idle(); check("br_next_pc", pc, 16'h0102);

    // siic beats redirect; rti returns.
    goto_pc(16'h0020);
    step(1'b0, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b0);
    check("exc_pc", pc, 16'h0002);
    check("exc_epc", epc, 16'h0022);
    check("exc_in", 16'(in_exc), 16'h1);
    idle(); idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("rti_pc", pc, 16'h0022);
    check("rti_in", 16'(in_exc), 16'h0);
    check("rti_flush", 16'(flush), 16'h1);
    idle();

    // Wrap cases.
    goto_pc(16'hFFFE);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("wrap_epc", epc, 16'h0000);
    check("wrap_exc_pc", pc, 16'h0002);
    idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);   // rti with odd-free epc 0000
    idle();
    goto_pc(16'hFFFE);
    idle(); check("wrap_seq_pc", pc, 16'h0000);

    // Stall holds; redirect/siic in FLUSH ignored; odd target passes through.
    goto_pc(16'h0040);
    repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("stall_pc", pc, 16'h0040);
    step(1'b0, 1'b1, 16'h0081, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0123, 1'b1, 1'b0, 1'b0);
    check("flush_ign_pc", pc, 16'h0081);
    check("flush_ign_in", 16'(in_exc), 16'h0);
    idle(); check("flush_ign_next", pc, 16'h0083);

    // Halt is terminal; reset recovers.
    goto_pc(16'h0050);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("halt_h", 16'(halted), 16'h1);
    step(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("halt_frozen_pc", pc, 16'h0050);
    reset_pulse();
    idle(); check("post_halt_pc", pc, 16'h0002);

    // Halt honoured inside FLUSH; reset asserted mid-FLUSH.
    step(1'b0, 1'b1, 16'h0070, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("flush_halt", 16'(halted), 16'h1);
    reset_pulse();
    step(1'b0, 1'b1, 16'h0090, 1'b0, 1'b0, 1'b0);
    reset_pulse();
    idle();

    // Nested exception inside a handler.
    goto_pc(16'h0020);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
`ifdef NESTED_EXC_GUARD_EN
    check("nest_epc", epc, 16'h0022);
    check("nest_err", 16'(err), 16'h1);
    check("nest_halt", 16'(halted), 16'h1);
`else
    check("nest_epc", epc, 16'h0004);
    check("nest_err", 16'(err), 16'h0);
`endif
    reset_pulse();

    // Random burst against the model (halt kept rare).
    for (int i = 0; i < 300; i++) begin
      logic [15:0] rt;
      rt = 16'($urandom);
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), rt,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) == 0));
      if (m_st == 2 && $urandom_range(0, 3) == 0) reset_pulse();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC and EPC registers and picks the next-PC source every cycle: sequential, branch/jump redirect, SIIC exception vector, RTI return, or hold.
- Feeds the fetch stage.
- Takes redirect targets from the next-PC adder logic.
- Inserts a one-cycle fetch-flush bubble on every control transfer and halts the machine on HALT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- EXC_VECTOR, 16'h0002, PC loaded on SIIC exception entry.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard stall; hold PC.
- redirect  input  1  taken branch/jump this cycle.
- target  input  16  redirect destination, computed externally.
- siic  input  1  illegal-instruction exception request.
- rti  input  1  return-from-interrupt.
- halt  input  1  HALT instruction retired.
- pc  output  16  current fetch PC (registered).
- pc_plus2  output  16  pc + 2, combinational, mod 2^16.
- epc  output  16  saved exception return address (registered).
- flush  output  1  fetch bubble; discard instruction fetched this cycle.
- in_exc  output  1  inside an exception handler.
- halted  output  1  machine stopped.
- err  output  1  sticky fault flag.

Behaviour:
- Reset (rst_n=0, asynchronous) forces pc=RESET_PC, epc=16'h0000, state=RUN, flush=0, in_exc=0, halted=0, err=0.
- All state updates happen on the rising clk edge. pc_plus2 wraps: 16'hFFFE -> 16'h0000.
- State machine has three states: RUN, FLUSH, HALT. flush=1 only in FLUSH. halted=1 only in HALT.
- RUN evaluates events in fixed priority order. The highest active event wins; lower ones are dropped with no queuing.
  1. halt: pc holds, state -> HALT.
  2. siic: epc <= pc_plus2, pc <= EXC_VECTOR, in_exc <= 1, state -> FLUSH.
  3. rti: pc <= epc, in_exc <= 0, state -> FLUSH. epc is unchanged.
  4. redirect: pc <= target, state -> FLUSH.
  5. stall: pc holds, state stays RUN.
  6. none: pc <= pc_plus2.
- FLUSH lasts exactly one cycle: pc holds (fetching the new target), then state -> RUN.
  - siic, rti, redirect and stall are ignored in FLUSH; their sources are being squashed.
  - halt in FLUSH is honoured: state -> HALT.
- Latency: an event sampled at edge N makes the new pc visible after edge N. flush is high for the cycle between edges N and N+1.
- HALT is terminal until reset. pc, epc and in_exc are frozen and all inputs are ignored.
- rti with in_exc=0 is legal: it jumps to the current epc.
- target LSB is not checked; it is passed through unchanged.
- Reset asserted mid-FLUSH or in HALT returns to the reset values immediately.

Optional Feature:
- Macro NESTED_EXC_GUARD_EN.
- Defined: siic in RUN while in_exc=1 does not overwrite epc. It sets err <= 1 (sticky) and state -> HALT; pc holds.
- Undefined: nested siic behaves like any siic (epc overwritten, vector taken) and err stays 0 permanently.

Test Plan:
- Reset release with no inputs -> pc reads 0000, 0002, 0004, 0006 on successive cycles; flush=0.
- At pc=0010, redirect=1, target=0100 -> next cycle pc=0100, flush=1. Following cycle pc=0100, flush=0. Then pc=0102.
- At pc=0020, siic=1 and redirect=1 together -> pc=0002, epc=0022, in_exc=1, flush=1. Later rti=1 -> pc=0022, in_exc=0, flush=1.
- At pc=FFFE, siic=1 -> epc=0000, pc=0002. Separately, free-running from pc=FFFE -> pc=0000.
- stall=1 for 3 cycles at pc=0040 -> pc stays 0040. redirect arriving during the FLUSH cycle -> ignored, pc unaffected.
- halt=1 at pc=0050 -> halted=1, pc frozen at 0050 despite redirect/siic. rst_n pulse low -> pc=0000, halted=0.
- With NESTED_EXC_GUARD_EN: siic, then a second siic in the handler with epc=0022 -> err=1, halted=1, epc stays 0022.
